key_debouncer: RTL
==================

// Module: key_debouncer
// PURPOSE
//  Conditions raw push-button inputs before they reach the memory-mapped key controller.
//  Each key gets a 2-flop synchronizer and an independent stability counter.
//  The output changes only after the synchronized input has held a new level for DEBOUNCE_CYCLES clocks.
//  Output `keys` drives the key controller's `keys` input directly. Polarity is unchanged (board keys are active-low).
// PARAMETERS
//  NKEYS            4       number of keys debounced in parallel
//  DEBOUNCE_CYCLES  500000  clocks a new level must persist before acceptance (10 ms @ 50 MHz); min 1
//  CNT_BITS         20      per-key counter width; must satisfy 2**CNT_BITS > DEBOUNCE_CYCLES-1
// PORTS
//  clk       in   1      system clock; single clock domain
//  reset     in   1      synchronous, active-high reset
//  keys_raw  in   NKEYS  asynchronous board key pins, active-low, idle = 1
//  keys      out  NKEYS  debounced, synchronized key levels, same polarity as keys_raw
//  busy      out  NKEYS  per key: 1 while that key's counter is running (sync level != keys)
//  press     out  NKEYS  only when KEY_DEBOUNCE_PRESS_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset, sampled on posedge clk when reset==1:
//    sync0 = sync1 = all 1s; keys = all 1s; counters = 0; busy = 0; press = 0.
//  - Synchronizer: sync0 <= keys_raw; sync1 <= sync0. Only sync1 is used downstream.
//  - Per key i, evaluated every posedge clk when not in reset:
//    - sync1[i] == keys[i]: cnt[i] <= 0. This restarts the count on any glitch shorter than DEBOUNCE_CYCLES.
//    - sync1[i] != keys[i] and cnt[i] <  DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//    - sync1[i] != keys[i] and cnt[i] == DEBOUNCE_CYCLES-1: keys[i] <= sync1[i]; cnt[i] <= 0.
//  - Latency: a clean level change on keys_raw[i] appears on keys[i] exactly DEBOUNCE_CYCLES+2 rising edges later.
//  - busy[i] is combinational: (sync1[i] != keys[i]).
//  - Counter never wraps. It saturates by acceptance at DEBOUNCE_CYCLES-1.
//  - With DEBOUNCE_CYCLES==1, keys follows sync1 with 1 extra cycle (total latency 3).
//  - Keys are fully independent. Simultaneous transitions on several keys are each accepted on their own count.
//  - A bounce back to the old level at any count clears that key's counter. keys[i] does not toggle.
//  - Reset asserted mid-count: counter discarded; keys returns to all 1s.
//    After reset, a held-down key is re-accepted after DEBOUNCE_CYCLES+2 edges.
//  - keys changes at most once per DEBOUNCE_CYCLES clocks per key. The key controller therefore sees one change per press/release.
// CONFIGURATION
//  KEY_DEBOUNCE_PRESS_EN
//  - defined: port `press` [NKEYS-1:0] is registered.
//    - press[i] = 1 for exactly one cycle, the cycle after keys[i] goes 1->0 (debounced press).
//    - Releases (0->1) produce no pulse. Reset value 0.
//  - undefined: `press` port and its logic are absent. All other behaviour is identical.
// TESTING  (bench uses DEBOUNCE_CYCLES=8, CNT_BITS=4, NKEYS=4)
//  1 reset 3 cycles, keys_raw=4'hF -> keys=4'hF, busy=0; press=0 with macro defined.
//  2 keys_raw 4'hF->4'hE held -> busy[0]=1 after 2 edges; keys=4'hE exactly 10 edges after the change; busy[0]=0 the same cycle.
//  3 keys_raw[1] low for 5 cycles then high -> keys stays 4'hF; busy[1] pulses; cnt[1] returns to 0.
//  4 keys_raw 4'hF->4'h5 (keys 1 and 3 low) on one edge -> keys=4'h5 on the same edge, 10 edges later; no intermediate value.
//  5 keys_raw[2] low, reset pulsed 1 cycle at count 5 -> keys=4'hF after reset; keys=4'hB 10 edges after reset deasserts.
//  6 macro defined, press key0 then release -> one 1-cycle press=4'h1 pulse after keys=4'hE; no pulse on release.

Source files
------------

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchronizer plus per-key stability counter; optional press pulse under KEY_DEBOUNCE_PRESS_EN
module key_debouncer #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] keys,
  output logic [NKEYS-1:0] busy
`ifdef KEY_DEBOUNCE_PRESS_EN
  ,
  output logic [NKEYS-1:0] press
`endif
);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  logic [NKEYS-1:0]    r_sync0;
  logic [NKEYS-1:0]    r_sync1;
  logic [NKEYS-1:0]    r_keys;
  logic [CNT_BITS-1:0] r_cnt [NKEYS];
`ifdef KEY_DEBOUNCE_PRESS_EN
  logic [NKEYS-1:0]    r_press;
  assign press = r_press;
`endif
  assign keys = r_keys;
  assign busy = r_sync1 ^ r_keys;
  // synchronize raw pins, then accept a new level once it has held for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= '1;
      r_sync1 <= '1;
      r_keys  <= '1;
      for (int i = 0; i < NKEYS; i++) r_cnt[i] <= '0;
`ifdef KEY_DEBOUNCE_PRESS_EN
      r_press <= '0;
`endif
    end else begin
      r_sync0 <= keys_raw;
      r_sync1 <= r_sync0;
`ifdef KEY_DEBOUNCE_PRESS_EN
      r_press <= '0;
`endif
      for (int i = 0; i < NKEYS; i++) begin
        if (r_sync1[i] == r_keys[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_keys[i] <= r_sync1[i];
          r_cnt[i]  <= '0;
`ifdef KEY_DEBOUNCE_PRESS_EN
          r_press[i] <= ~r_sync1[i];
`endif
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_BITS'(1);
        end
      end
    end
  end
endmodule
